// File: rtl/axis_pack_fifo.sv
// axis_pack_fifo
//   Packs RATIO narrow input words (first word in the LSBs) into one
//   OUT_W = IN_W*RATIO beat and buffers beats in a DEPTH-entry first-word
//   fall-through FIFO. The FIFO drives an AXI4-Stream master with tready
//   backpressure. tlast is asserted every PKT_LEN beats and on flush-closed
//   short beats, which carry a partial tstrb.
//
//   Optional feature: define AXIS_PACK_FIFO_DROP_CNT_EN to add the 16-bit
//   saturating drop_cnt output. Without the macro, drop_cnt does not exist.
//
// Ports
//   m00_axis_aclk    clock; all logic uses the rising edge
//   m00_axis_areset  synchronous active-high reset
//   wr_en / wr_data  input word strobe and word (always accepted)
//   flush            pulse: close the partial beat and end the packet
//   full / level     FIFO full flag and occupancy
//   overflow         sticky: a beat was dropped at push time
//   m00_axis_t*      AXI4-Stream master (tdata, tstrb, tlast, tvalid, tready)
//   drop_cnt         (optional) count of dropped beats, saturating
module axis_pack_fifo #(
  parameter int IN_W    = 16,
  parameter int RATIO   = 2,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 8
) (
  input  logic                       m00_axis_aclk,
  input  logic                       m00_axis_areset,
  input  logic                       wr_en,
  input  logic [IN_W-1:0]            wr_data,
  input  logic                       flush,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
`ifdef AXIS_PACK_FIFO_DROP_CNT_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic [IN_W*RATIO-1:0]      m00_axis_tdata,
  output logic [IN_W*RATIO/8-1:0]    m00_axis_tstrb,
  output logic                       m00_axis_tlast,
  output logic                       m00_axis_tvalid,
  input  logic                       m00_axis_tready
);

  localparam int OUT_W   = IN_W * RATIO;
  localparam int SW      = OUT_W / 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int SLOT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int ENTRY_W = OUT_W + SW + 1;

  // Byte-strobe mask with the low nslots*IN_W/8 bits set
  function automatic logic [SW-1:0] strb_mask(input logic [SLOT_W:0] nslots);
    strb_mask = '0;
    for (int i = 0; i < SW; i++) begin
      if (i < int'(nslots) * (IN_W / 8)) strb_mask[i] = 1'b1;
      else                               strb_mask[i] = 1'b0;
    end
  endfunction

  logic [OUT_W-1:0]   pack_r;
  logic [SLOT_W-1:0]  slot_r;
  logic [BEAT_W-1:0]  beat_r;
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        count_r;
  logic               overflow_r;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
`ifdef AXIS_PACK_FIFO_DROP_CNT_EN
  logic [15:0]        drop_cnt_r;
`endif

  logic [OUT_W-1:0]   packed_s;
  logic [SLOT_W:0]    filled_s;
  logic               complete_s;
  logic               push_req_s;
  logic               push_ok_s;
  logic               push_last_s;
  logic [SW-1:0]      strb_s;
  logic               pop_s;
  logic               valid_s;
  logic [ENTRY_W-1:0] head_s;

  // Merge the current word into the packing register and decide whether a beat is pushed
  always_comb begin
    packed_s = pack_r;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_en && (slot_r == SLOT_W'(i))) packed_s[i*IN_W +: IN_W] = wr_data;
      else                                 packed_s[i*IN_W +: IN_W] = pack_r[i*IN_W +: IN_W];
    end
    complete_s = wr_en && (slot_r == SLOT_W'(RATIO - 1));
    // Number of slots holding data once this cycle's word is included
    if (complete_s) filled_s = (SLOT_W+1)'(RATIO);
    else            filled_s = {1'b0, slot_r} + (SLOT_W+1)'(wr_en);
    // A flush with nothing packed is a no-op
    push_req_s  = complete_s || (flush && (filled_s != (SLOT_W+1)'(0)));
    // No pop credit at full: a simultaneous pop does not make room
    push_ok_s   = push_req_s && (count_r != (AW+1)'(DEPTH));
    push_last_s = flush || (beat_r == BEAT_W'(PKT_LEN - 1));
    strb_s      = strb_mask(filled_s);
    valid_s     = (count_r != (AW+1)'(0));
    pop_s       = valid_s && m00_axis_tready;
    head_s      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Packer, pointers, occupancy and overflow state
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      pack_r     <= '0;
      slot_r     <= '0;
      beat_r     <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
`ifdef AXIS_PACK_FIFO_DROP_CNT_EN
      drop_cnt_r <= 16'h0000;
`endif
    end else begin
      // Any push attempt, kept or dropped, empties the packer so unfilled bits stay 0
      if (push_req_s) begin
        pack_r <= '0;
        slot_r <= '0;
      end else if (wr_en) begin
        pack_r <= packed_s;
        slot_r <= slot_r + SLOT_W'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
        beat_r   <= push_last_s ? BEAT_W'(0) : beat_r + BEAT_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
`ifdef AXIS_PACK_FIFO_DROP_CNT_EN
        if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'h0001;
`endif
      end
    end
  end

  // Beat storage; contents are discarded on reset by clearing the pointers
  always_ff @(posedge m00_axis_aclk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= {push_last_s, strb_s, packed_s};
  end

  // Stream outputs come straight from the head entry and are zero when empty
  always_comb begin
    m00_axis_tvalid = valid_s;
    if (valid_s) begin
      m00_axis_tdata = head_s[OUT_W-1:0];
      m00_axis_tstrb = head_s[OUT_W +: SW];
      m00_axis_tlast = head_s[ENTRY_W-1];
    end else begin
      m00_axis_tdata = '0;
      m00_axis_tstrb = '0;
      m00_axis_tlast = 1'b0;
    end
  end

  assign full     = (count_r == (AW+1)'(DEPTH));
  assign level    = count_r;
  assign overflow = overflow_r;
`ifdef AXIS_PACK_FIFO_DROP_CNT_EN
  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: doc/axis_pack_fifo.md
Name: axis_pack_fifo

Overview:
- Single-clock, parametrised successor to the 16-bit-in / 32-bit-out FIFO-to-AXI-stream master.
- Packs RATIO narrow input words into one OUT_W-bit beat and buffers beats in a DEPTH-entry FIFO.
- Drives an AXI4-Stream master with full tready backpressure, tlast every PKT_LEN beats, and flush-driven short packets with partial tstrb.
- Sits between a sample producer and a PCIe/DMA AXI-stream slave.

Parameters:
- IN_W, 16, input word width; multiple of 8.
- RATIO, 2, input words per output beat; >=1; OUT_W = IN_W*RATIO.
- DEPTH, 16, FIFO entries; power of 2, >=2.
- PKT_LEN, 8, beats per packet; >=1.

Ports:
- m00_axis_aclk  in  1  clock, all logic rising edge.
- m00_axis_areset  in  1  synchronous reset, active-high.
- wr_en  in  1  wr_data valid this cycle.
- wr_data  in  IN_W  input word.
- flush  in  1  pulse: close partial beat and end packet.
- full  out  1  FIFO count == DEPTH.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a beat was dropped.
- m00_axis_tdata  out  OUT_W  stream data.
- m00_axis_tstrb  out  OUT_W/8  byte qualifiers.
- m00_axis_tlast  out  1  last beat of packet.
- m00_axis_tvalid  out  1  beat available.
- m00_axis_tready  in  1  sink accepts.

Behaviour:
- Reset: all pointers, slot counter, beat counter, count and overflow go to 0. Outputs after reset: tvalid=0, tdata=0, tstrb=0, tlast=0, full=0, level=0, overflow=0.
- Reset mid-packet discards the partial beat and all FIFO contents.
- Packer:
  - Slot counter s runs 0..RATIO-1.
  - When wr_en=1, wr_data is written to pack_reg[s*IN_W +: IN_W], so the first word lands in the LSBs.
  - When s=RATIO-1 with wr_en, the packed beat is presented for push with tstrb all ones, and s wraps to 0.
  - Input words are always accepted. Drops occur only at push time.
- Flush:
  - flush=1 with s>0 and no completing wr_en: push the partial beat. tstrb has the low s*IN_W/8 bits set. Unfilled data bits are 0. tlast=1. s resets to 0.
  - flush together with a wr_en that completes a beat: a normal full beat is pushed, marked tlast=1.
  - flush together with a non-completing wr_en: that word is included first, then a partial beat of s+1 slots is pushed.
  - flush with s=0 and no wr_en: no action.
- tlast generation:
  - Stored per entry, computed at push time.
  - tlast=1 when beat counter == PKT_LEN-1 or the beat is flush-terminated.
  - The beat counter resets to 0 after any tlast beat and otherwise increments per successful push.
- Push:
  - Succeeds only when count < DEPTH. There is no same-cycle pop credit at full.
  - If full, the beat is dropped and overflow is set. The beat counter is not advanced, and the slot counter still wraps.
- Pop:
  - Occurs on tvalid & tready. count/level updates on the next edge.
  - Push and pop in the same cycle leave count unchanged.
- Output:
  - tvalid = (count != 0).
  - tdata/tstrb/tlast = mem[rd_ptr] when tvalid, else 0.
  - Latency: a beat pushed at edge N gives tvalid=1 from cycle N+1 (first-word fall-through).
  - While tvalid & !tready, tdata/tstrb/tlast hold stable.
- Pointers are $clog2(DEPTH)+1 bits with natural wrap. full/empty are derived from count.

Optional Feature:
- Macro AXIS_PACK_FIFO_DROP_CNT_EN.
- When defined, adds output port drop_cnt (16 bits). It increments once per dropped beat, saturates at 16'hFFFF, and resets to 0.
- When undefined, the port and counter do not exist. overflow behaviour is identical in both builds.

Test Plan:
- Reset, then wr_en with words 16'h1111, 16'h2222, tready=1 -> one cycle after the push edge: tdata=32'h2222_1111, tstrb=4'hF, tvalid=1 for one cycle, tlast=0.
- 16 consecutive words, tready=1, PKT_LEN=8 -> 8 beats, tlast=1 only on beat 8, level returns to 0.
- tready=0, 40 words (20 beats) -> full=1 and level=16 after the 16th push, overflow=1, drop_cnt=4 (macro on). Then tready=1 -> exactly 16 beats drain, in order.
- Three words then flush (RATIO=2, beat count 1) -> beat 2 has tstrb=4'h3, upper 16 data bits 0, tlast=1. The next packet restarts with tlast on its 8th beat.
- tready toggled 1010... with continuous input -> no beat lost or duplicated, data stable while stalled, push+pop cycles keep level constant.
- Assert reset while level=5 and s=1 -> next cycle: tvalid=0, level=0, overflow=0. A following 2-word burst produces tdata built from the post-reset words only.
